periodic_framer_v2: RTL

- Parametrised, run-time-configurable sample framer for OFDM receive chains.
- Sits between the Schmidl-Cox sync detector and the FFT block.
- On a trigger beat it:
  - skips a programmable offset,
  - then passes frames of frame_len samples separated by dropped gaps of gap_len samples (the cyclic prefix), up to num_frames frames.
- Generalises the fixed framer with:
  - parametrised data and length widths,
  - a retrigger mode,
  - continuous (unbounded) mode,
  - end-of-burst marking.

---
 rtl/periodic_framer_v2_pkg.sv | 22 ++
 rtl/periodic_framer_v2_if.sv | 25 ++
 rtl/periodic_framer_v2_out_reg.sv | 46 ++++
 rtl/periodic_framer_v2.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/periodic_framer_v2_pkg.sv
// periodic_framer_v2 shared types: FSM state encoding and settings-bus offsets.
// Imported by the framer top and its output register.
package periodic_framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OFFSET,
        FRAME,
        GAP
    } state_t;

    localparam int SR_FRAME_LEN  = 0;
    localparam int SR_GAP_LEN    = 1;
    localparam int SR_OFFSET     = 2;
    localparam int SR_NUM_FRAMES = 3;
    localparam int SR_MODE       = 4;

    function automatic logic [7:0] sr_addr(input int base, input int off);
        return 8'(base + off);
    endfunction

endpackage

// File: rtl/periodic_framer_v2_if.sv
// periodic_framer_v2 stream interface: input samples with trigger, framed output.
// The framer takes the slave side, the surrounding chain the master side.
interface periodic_framer_v2_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tvalid;
    logic             i_tready;
    logic             i_trig;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_teob;
    logic             o_tvalid;
    logic             o_tready;

    modport slave (
        input  i_tdata, i_tvalid, i_trig, o_tready,
        output i_tready, o_tdata, o_tlast, o_teob, o_tvalid
    );

    modport master (
        output i_tdata, i_tvalid, i_trig, o_tready,
        input  i_tready, o_tdata, o_tlast, o_teob, o_tvalid
    );
endinterface

// File: rtl/periodic_framer_v2_out_reg.sv
// periodic_framer_v2 output stage: one-deep AXI-stream flop with tlast/teob
// sideband, full throughput, contents held while the sink stalls.
module periodic_framer_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    input  logic             in_eob_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] o_tdata_o,
    output logic             o_tlast_o,
    output logic             o_teob_o,
    output logic             o_tvalid_o,
    input  logic             o_tready_i
);
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic             eob_q;
    logic             valid_q;

    assign in_ready_o = !valid_q || o_tready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            eob_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
                last_q <= in_last_i;
                eob_q  <= in_eob_i;
            end
        end
    end

    assign o_tdata_o  = data_q;
    assign o_tlast_o  = last_q;
    assign o_teob_o   = eob_q;
    assign o_tvalid_o = valid_q;
endmodule

// File: rtl/periodic_framer_v2.sv
// periodic_framer_v2: trigger-aligned OFDM sample framer (offset, frame, CP gap).
// Optional counters enabled by PERIODIC_FRAMER_STATS_EN.
module periodic_framer_v2
    import periodic_framer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int SR_BASE = 130
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    periodic_framer_v2_if.slave  axis,
    output logic                 busy
`ifdef PERIODIC_FRAMER_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_frames,
    output logic [15:0]          stat_retrigs
`endif
);
    typedef struct packed {
        logic             retrig;
        logic [CNT_W-1:0] num;
        logic [LEN_W-1:0] off;
        logic [LEN_W-1:0] gap;
        logic [LEN_W-1:0] flen;
    } cfg_t;

    cfg_t             sh_q;
    cfg_t             wk_q, wk_d;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    logic             out_rdy;
    logic             beat;
    logic             trig_rt;
    logic             emit, emit_last, emit_eob;
    logic             frame_done, retrig_acc;
    logic             start, frame_beat;
    cfg_t             cfg;
    logic [LEN_W-1:0] fcnt;
    logic [CNT_W-1:0] fcount, fnext;
    logic             unused_bits;

    assign unused_bits = ^set_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q <= '0;
        end else if (set_stb) begin
            if (set_addr == sr_addr(SR_BASE, SR_FRAME_LEN))
                sh_q.flen <= set_data[LEN_W-1:0];
            if (set_addr == sr_addr(SR_BASE, SR_GAP_LEN))
                sh_q.gap <= set_data[LEN_W-1:0];
            if (set_addr == sr_addr(SR_BASE, SR_OFFSET))
                sh_q.off <= set_data[LEN_W-1:0];
            if (set_addr == sr_addr(SR_BASE, SR_NUM_FRAMES))
                sh_q.num <= set_data[CNT_W-1:0];
            if (set_addr == sr_addr(SR_BASE, SR_MODE))
                sh_q.retrig <= set_data[0];
        end
    end

    // A trigger beat may have to be emitted, so it waits for output space.
    assign axis.i_tready = (state_q == FRAME || axis.i_trig) ? out_rdy : 1'b1;
    assign beat    = axis.i_tvalid && axis.i_tready;
    assign trig_rt = axis.i_trig && wk_q.retrig;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frames_d   = frames_q;
        wk_d       = wk_q;
        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_eob   = 1'b0;
        frame_done = 1'b0;
        retrig_acc = 1'b0;
        start      = 1'b0;
        frame_beat = 1'b0;
        cfg        = wk_q;
        fcnt       = cnt_q;
        fcount     = frames_q;
        fnext      = frames_q;
        if (beat) begin
            unique case (state_q)
                IDLE: start = axis.i_trig;
                OFFSET: begin
                    if (trig_rt) begin
                        start      = 1'b1;
                        retrig_acc = 1'b1;
                    end else if (cnt_q == wk_q.off - LEN_W'(1)) begin
                        state_d = FRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
                GAP: begin
                    if (trig_rt) begin
                        start      = 1'b1;
                        retrig_acc = 1'b1;
                    end else if (cnt_q == wk_q.gap - LEN_W'(1)) begin
                        state_d = FRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
                FRAME: begin
                    if (trig_rt) begin
                        // Close the frame on the trigger; it is offset sample 0.
                        emit       = 1'b1;
                        emit_last  = 1'b1;
                        emit_eob   = 1'b1;
                        frame_done = 1'b1;
                        retrig_acc = 1'b1;
                        wk_d       = sh_q;
                        frames_d   = '0;
                        cnt_d      = LEN_W'(1);
                        if (sh_q.flen == '0) begin
                            state_d = IDLE;
                        end else if (sh_q.off <= LEN_W'(1)) begin
                            state_d = FRAME;
                            cnt_d   = '0;
                        end else begin
                            state_d = OFFSET;
                        end
                    end else begin
                        frame_beat = 1'b1;
                    end
                end
            endcase
            if (start) begin
                wk_d     = sh_q;
                frames_d = '0;
                cfg      = sh_q;
                fcnt     = '0;
                fcount   = '0;
                if (sh_q.flen == '0) begin
                    state_d = IDLE;
                end else if (sh_q.off == '0) begin
                    frame_beat = 1'b1;
                end else if (sh_q.off == LEN_W'(1)) begin
                    state_d = FRAME;
                    cnt_d   = '0;
                end else begin
                    state_d = OFFSET;
                    cnt_d   = LEN_W'(1);
                end
            end
            if (frame_beat) begin
                emit = 1'b1;
                if (fcnt == cfg.flen - LEN_W'(1)) begin
                    emit_last  = 1'b1;
                    frame_done = 1'b1;
                    cnt_d      = '0;
                    fnext      = (fcount == '1) ? fcount : fcount + CNT_W'(1);
                    frames_d   = fnext;
                    if (cfg.num != '0 && fnext == cfg.num) begin
                        emit_eob = 1'b1;
                        state_d  = IDLE;
                    end else if (cfg.gap == '0) begin
                        state_d = FRAME;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d   = fcnt + LEN_W'(1);
                    state_d = FRAME;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            frames_q <= '0;
            wk_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
            wk_q     <= wk_d;
        end
    end

    assign busy = (state_q != IDLE);

    periodic_framer_out_reg #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .in_valid_i(emit),
        .in_data_i (axis.i_tdata),
        .in_last_i (emit_last),
        .in_eob_i  (emit_eob),
        .in_ready_o(out_rdy),
        .o_tdata_o (axis.o_tdata),
        .o_tlast_o (axis.o_tlast),
        .o_teob_o  (axis.o_teob),
        .o_tvalid_o(axis.o_tvalid),
        .o_tready_i(axis.o_tready)
    );

`ifdef PERIODIC_FRAMER_STATS_EN
    logic [31:0] stat_frames_q;
    logic [15:0] stat_retrigs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames_q  <= '0;
            stat_retrigs_q <= '0;
        end else if (stat_clr) begin
            stat_frames_q  <= '0;
            stat_retrigs_q <= '0;
        end else begin
            if (frame_done)
                stat_frames_q <= stat_frames_q + 32'd1;
            if (retrig_acc && stat_retrigs_q != '1)
                stat_retrigs_q <= stat_retrigs_q + 16'd1;
        end
    end

    assign stat_frames  = stat_frames_q;
    assign stat_retrigs = stat_retrigs_q;
`else
    logic unused_stats;
    assign unused_stats = frame_done ^ retrig_acc;
`endif
endmodule
